// File: rtl/gray9_step_counter.sv
// gray9_step_counter
// Turns raw UP/DN buttons into a 0..8 position and outputs it as a registered
// Gray code for the 9-position Gray-to-binary converter. Each button passes
// through a synchronizer, a debouncer and a rising-edge detector. The counter
// also supports a parallel load, wrap/saturate at the ends, a wrap pulse, and
// an error pulse for an illegal load value.
module gray9_step_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYC     = 4,
  parameter int WRAP_EN     = 1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       UP,
  input  logic       DN,
  input  logic       LOAD,
  input  logic [3:0] LD_VAL,
  output logic [3:0] GOUT,
  output logic [3:0] POS,
  output logic       WRAP,
  output logic       ERR
);

  // Terminal debounce count. The level is accepted when the counter reaches
  // this value while the two levels still differ.
  localparam logic [7:0] DEB_LAST = 8'(DEB_CYC - 1);

  // Highest legal position.
  localparam logic [3:0] POS_MAX = 4'd8;

  // Per-button signals. Index 0 is UP and index 1 is DN.
  logic [1:0]             w_raw;
  logic [SYNC_STAGES-1:0] r_sync [2];
  logic [1:0]             w_synced;
  logic [7:0]             r_debCnt [2];
  logic [1:0]             r_deb;
  logic [1:0]             r_debPrev;
  logic [1:0]             w_req;
  logic                   w_upReq;
  logic                   w_dnReq;

  // Counter state and its next-state values.
  logic [3:0] r_pos;
  logic [3:0] r_gout;
  logic       r_wrap;
  logic       r_err;
  logic [3:0] w_nextPos;
  logic       w_nextWrap;
  logic       w_nextErr;

  assign w_raw    = {DN, UP};
  assign w_synced = {r_sync[1][SYNC_STAGES-1], r_sync[0][SYNC_STAGES-1]};

  // A step request is a rising edge of the debounced level.
  // Falling edges (button release) never move the counter.
  assign w_req   = r_deb & ~r_debPrev;
  assign w_upReq = w_req[0];
  assign w_dnReq = w_req[1];

  // Fixed position-to-Gray mapping. Codes change by one bit between
  // neighbours, except across the 8<->0 wrap.
  function automatic logic [3:0] grayOf(input logic [3:0] p);
    logic [3:0] g;
    case (p)
      4'd0:    g = 4'b0000;
      4'd1:    g = 4'b0001;
      4'd2:    g = 4'b0011;
      4'd3:    g = 4'b0010;
      4'd4:    g = 4'b0110;
      4'd5:    g = 4'b0111;
      4'd6:    g = 4'b0101;
      4'd7:    g = 4'b0100;
      4'd8:    g = 4'b1100;
      default: g = 4'b0000;
    endcase
    return g;
  endfunction

  // Shift each raw button through its own metastability synchronizer chain.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 2; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
      end
    end
  end

  // Accept a new synchronized level only after it has differed from the
  // debounced level for DEB_CYC consecutive cycles.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 2; i++) begin
        r_debCnt[i] <= '0;
      end
      r_deb <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_synced[i] != r_deb[i]) begin
          if (r_debCnt[i] == DEB_LAST) begin
            r_deb[i]    <= w_synced[i];
            r_debCnt[i] <= '0;
          end else begin
            r_debCnt[i] <= r_debCnt[i] + 8'd1;
          end
        end else begin
          r_debCnt[i] <= '0;
        end
      end
    end
  end

  // Remember last cycle's debounced levels for rising-edge detection.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_debPrev <= '0;
    end else begin
      r_debPrev <= r_deb;
    end
  end

  // Pick the next position. A load overrides any step. Opposing step
  // requests in the same cycle cancel each other.
  always_comb begin
    w_nextPos  = r_pos;
    w_nextWrap = 1'b0;
    w_nextErr  = 1'b0;
    if (LOAD) begin
      if (LD_VAL <= POS_MAX) begin
        w_nextPos = LD_VAL;
      end else begin
        w_nextErr = 1'b1;
      end
    end else if (w_upReq && !w_dnReq) begin
      if (r_pos == POS_MAX) begin
        if (WRAP_EN != 0) begin
          w_nextPos  = 4'd0;
          w_nextWrap = 1'b1;
        end
      end else begin
        w_nextPos = r_pos + 4'd1;
      end
    end else if (w_dnReq && !w_upReq) begin
      if (r_pos == 4'd0) begin
        if (WRAP_EN != 0) begin
          w_nextPos  = POS_MAX;
          w_nextWrap = 1'b1;
        end
      end else begin
        w_nextPos = r_pos - 4'd1;
      end
    end
  end

  // Register the position and its Gray code together so they always agree.
  // The pulse outputs last for exactly one cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pos  <= '0;
      r_gout <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_pos  <= w_nextPos;
      r_gout <= grayOf(w_nextPos);
      r_wrap <= w_nextWrap;
      r_err  <= w_nextErr;
    end
  end

  assign POS  = r_pos;
  assign GOUT = r_gout;
  assign WRAP = r_wrap;
  assign ERR  = r_err;

endmodule

// File: doc/gray9_step_counter.md
Name: gray9_step_counter

Overview:
- Produces the 4-bit Gray position code consumed by the 9-position Gray-to-binary converter stage.
- Takes raw UP/DN step buttons, synchronizes and debounces them, and steps a position counter 0..8.
- Presents the position as registered Gray code, so the downstream converter only ever sees the nine valid codes.
- Also supports a parallel load, a wrap/saturate mode, a wrap pulse and an error flag for illegal loads.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the UP/DN synchronizers (legal ≥2).
- DEB_CYC, 4: consecutive cycles a synchronized level must differ from the debounced level before it is accepted (legal 1..255).
- WRAP_EN, 1: 1 = wrap 8→0 and 0→8; 0 = saturate at 0 and 8.

Ports:
- CLK  input  1  single system clock, rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- UP  input  1  raw asynchronous up button, active high.
- DN  input  1  raw asynchronous down button, active high.
- LOAD  input  1  synchronous load strobe, one cycle.
- LD_VAL  input  4  binary position to load, legal 0..8.
- GOUT  output  4  registered Gray code of position; drives the converter's NIN.
- POS  output  4  registered binary position 0..8.
- WRAP  output  1  one-cycle pulse on a wrap step.
- ERR  output  1  one-cycle pulse on an illegal load.

Behaviour:
- Reset:
  - RST_N low asynchronously clears POS=0, GOUT=4'b0000, WRAP=0, ERR=0.
  - It also clears all synchronizer flops, debounced levels, debounce counters and edge-detect flops.
  - Reset asserted mid-debounce or mid-step discards all pending activity.
- Synchronizer: UP and DN each pass through a SYNC_STAGES-deep chain of flip-flops.
- Debounce, per input:
  - The counter increments each cycle the synchronized level differs from the debounced level.
  - The counter clears whenever the two are equal.
  - When the count reaches DEB_CYC-1 and the levels still differ, the debounced level takes the synchronized level at that edge and the counter clears.
  - Glitches shorter than DEB_CYC cycles are rejected.
- Step request: a rising edge of the debounced level (debounced=1, previous=0). Falling edges are ignored.
- Latency: with UP first sampled high at edge 1 and held, the debounced level rises at edge SYNC_STAGES+DEB_CYC, and POS/GOUT update at edge SYNC_STAGES+DEB_CYC+1 (7 at defaults).
- Priority, evaluated each cycle:
  - LOAD takes precedence over any step; a step request in the same cycle is dropped.
  - Simultaneous UP and DN step requests: no move, no pulse.
- Load:
  - LD_VAL ≤ 8: POS=LD_VAL next edge; WRAP=0.
  - LD_VAL > 8: POS unchanged; ERR=1 for exactly one cycle.
- Step up:
  - POS<8: POS+1.
  - POS=8 with WRAP_EN=1: POS=0 and WRAP=1 for one cycle.
  - POS=8 with WRAP_EN=0: POS stays 8, no pulse.
- Step down:
  - POS>0: POS−1.
  - POS=0 with WRAP_EN=1: POS=8 and WRAP=1.
  - POS=0 with WRAP_EN=0: POS stays 0, no pulse.
- GOUT is registered together with POS using the fixed mapping 0:0000, 1:0001, 2:0011, 3:0010, 4:0110, 5:0111, 6:0101, 7:0100, 8:1100.
  - GOUT and POS are always consistent in the same cycle.
  - Exactly one GOUT bit changes on each single step. The wrap transitions 8↔0 change two bits; this is accepted.
- WRAP and ERR return to 0 in every cycle without their triggering event.
- Button held high across reset release: the debounced level restarts at 0, so exactly one step occurs after the full latency.

Test Plan:
- Reset then hold UP high from edge 1 (defaults): POS 0→1 and GOUT 0000→0001 at edge 7; no further change while UP stays high.
- Nine debounced UP presses from 0 (WRAP_EN=1): GOUT walks 0001,0011,0010,0110,0111,0101,0100,1100,0000. WRAP pulses one cycle on the 8→0 step only.
- UP glitch high for 3 cycles (DEB_CYC=4): no change to POS or GOUT. DN press at POS=0 with WRAP_EN=0: POS stays 0, WRAP stays 0.
- LOAD with LD_VAL=5: POS=5, GOUT=0111. Then LOAD with LD_VAL=9: POS stays 5, ERR=1 for one cycle.
- LOAD=1 with LD_VAL=2 in the same cycle as an UP step request at POS=6: POS=2. UP and DN step requests in the same cycle: POS unchanged.
- RST_N pulsed low while POS=7 and a DN debounce is in progress: outputs are 0 immediately. After release with DN still high, exactly one step 0→8 (WRAP=1) after 7 edges.
